// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace-encoder sync path.
package trdb_pkg;

   // Packet format codes understood by the packet emitter.
   localparam logic [1:0] F_BRANCH_FULL = 2'b01;
   localparam logic [1:0] F_SYNC        = 2'b11;

   // Format-3 subformat for a start/resync packet.
   localparam logic [1:0] SF_START      = 2'b00;

   // Sync controller sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_QUAL = 2'd1,
      ST_FLUSH     = 2'd2,
      ST_SYNC      = 2'd3
   } trdb_sync_state_e;

endpackage

// File: rtl/trdb_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over enable;
// once the count reaches MAX it holds there until cleared.
module trdb_sat_counter #(
   parameter int unsigned MAX   = 1024,
   parameter int unsigned WIDTH = $clog2(MAX + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear, else increment until saturated.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != MAX_VAL)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/trdb_sync_ctrl.sv
// Sync-packet controller: turns a trace-enable rising edge or the resync
// counter's max level into an optional branch-map flush packet followed by
// a format-3 start sync packet, then pulses resync_rst_o to restart counting.
//
// Handshake: pkt_valid_o and pkt_format_o/pkt_subformat_o are registered from
// the next state and only change when the FSM leaves FLUSH or SYNC, which it
// does only on a cycle where pkt_ready_i is sampled high with pkt_valid_o
// high; a transfer is exactly one such cycle. Only rst_i may drop a request
// early.
module trdb_sync_ctrl
   import trdb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 1024
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       trace_enabled_i,
   input  logic       resync_max_i,
   input  logic       inst_qualified_i,
   input  logic       branch_map_empty_i,
   input  logic       pkt_ready_i,
   output logic       pkt_valid_o,
   output logic [1:0] pkt_format_o,
   output logic [1:0] pkt_subformat_o,
   output logic       resync_rst_o,
   output logic       resync_pending_o,
   output logic       resync_overdue_o
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [1:0] SF_NONE = 2'b00;

   trdb_sync_state_e state_q, state_d;

   logic       trace_en_dly_q, trace_en_dly_d;
   logic       start_flag_q, start_flag_d;
   logic       pkt_valid_q, pkt_valid_d;
   logic [1:0] pkt_format_q, pkt_format_d;
   logic [1:0] pkt_subformat_q, pkt_subformat_d;
   logic       resync_rst_q, resync_rst_d;
   logic       resync_pending_q, resync_pending_d;

   logic             trace_rise;
   logic             sync_done;
   logic             cnt_en;
   logic             cnt_clr;
   logic [CNT_W-1:0] overdue_cnt;

   assign trace_rise = trace_enabled_i & ~trace_en_dly_q;
   assign sync_done  = (state_q == ST_SYNC) & pkt_ready_i;

   // Sequencing: wait for a trigger, then a qualified instruction, then
   // emit flush (if branches are outstanding) and sync packets.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (trace_enabled_i && (start_flag_q || trace_rise || resync_max_i)) begin
               state_d = ST_WAIT_QUAL;
            end
         end
         ST_WAIT_QUAL: begin
            // A disabled tracer has nothing to qualify; the trigger is
            // re-evaluated once tracing comes back.
            if (!trace_enabled_i) begin
               state_d = ST_IDLE;
            end else if (inst_qualified_i) begin
               state_d = branch_map_empty_i ? ST_SYNC : ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (pkt_ready_i) begin
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (pkt_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Start flag remembers an enable edge until a sync is delivered; a fresh
   // edge in the delivery cycle takes priority so it is not lost.
   always_comb begin
      trace_en_dly_d = trace_enabled_i;
      start_flag_d   = start_flag_q;
      if (trace_rise) begin
         start_flag_d = 1'b1;
      end else if (sync_done) begin
         start_flag_d = 1'b0;
      end
   end

   // Output decode from the next state so every output is a flop.
   always_comb begin
      pkt_valid_d      = 1'b0;
      pkt_format_d     = 2'b00;
      pkt_subformat_d  = 2'b00;
      resync_pending_d = (state_d != ST_IDLE);
      resync_rst_d     = sync_done;
      case (state_d)
         ST_FLUSH: begin
            pkt_valid_d     = 1'b1;
            pkt_format_d    = F_BRANCH_FULL;
            pkt_subformat_d = SF_NONE;
         end
         ST_SYNC: begin
            pkt_valid_d     = 1'b1;
            pkt_format_d    = F_SYNC;
            pkt_subformat_d = SF_START;
         end
         default: ;
      endcase
   end

   // Overdue timer counts unqualified cycles spent waiting; leaving the
   // wait state by any route clears it.
   always_comb begin
      cnt_en  = (state_q == ST_WAIT_QUAL) && !inst_qualified_i;
      cnt_clr = (state_q == ST_WAIT_QUAL) && (state_d != ST_WAIT_QUAL);
   end

   trdb_sat_counter #(
      .MAX   (MAX_WAIT),
      .WIDTH (CNT_W)
   ) u_overdue_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (overdue_cnt)
   );

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= ST_IDLE;
         trace_en_dly_q   <= 1'b0;
         start_flag_q     <= 1'b0;
         pkt_valid_q      <= 1'b0;
         pkt_format_q     <= 2'b00;
         pkt_subformat_q  <= 2'b00;
         resync_rst_q     <= 1'b0;
         resync_pending_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         trace_en_dly_q   <= trace_en_dly_d;
         start_flag_q     <= start_flag_d;
         pkt_valid_q      <= pkt_valid_d;
         pkt_format_q     <= pkt_format_d;
         pkt_subformat_q  <= pkt_subformat_d;
         resync_rst_q     <= resync_rst_d;
         resync_pending_q <= resync_pending_d;
      end
   end

   assign pkt_valid_o      = pkt_valid_q;
   assign pkt_format_o     = pkt_format_q;
   assign pkt_subformat_o  = pkt_subformat_q;
   assign resync_rst_o     = resync_rst_q;
   assign resync_pending_o = resync_pending_q;
   assign resync_overdue_o = (overdue_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: tb/tb_trdb_sync_ctrl.sv
// Bench for trdb_sync_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based reference model and a packet scoreboard.
module tb_trdb_sync_ctrl;

   localparam int unsigned MAX_WAIT = 8;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       te, rm, iq, bme, rdy;
   logic       pkt_valid;
   logic [1:0] pkt_format, pkt_subformat;
   logic       resync_rst, resync_pending, resync_overdue;

   always #5 clk = ~clk;

   trdb_sync_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .trace_enabled_i    (te),
      .resync_max_i       (rm),
      .inst_qualified_i   (iq),
      .branch_map_empty_i (bme),
      .pkt_ready_i        (rdy),
      .pkt_valid_o        (pkt_valid),
      .pkt_format_o       (pkt_format),
      .pkt_subformat_o    (pkt_subformat),
      .resync_rst_o       (resync_rst),
      .resync_pending_o   (resync_pending),
      .resync_overdue_o   (resync_overdue)
   );

   int n_vec  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   // Scoreboard: {format, subformat} of every packet the model expects.
   logic [3:0] exp_q[$];

   // ---------------- reference model ----------------
   // A sync is "waiting" for a qualified instruction, then a list of packets
   // remains to be delivered; an empty list after a sync means a counter reset.
   logic [1:0] pkt_q[$];
   bit         m_prev_te, m_flag, m_wait, m_rst_pulse;
   int         m_cnt;
   bit         m_rise, m_sync_done;
   logic [1:0] m_f;

   initial begin
      m_prev_te = 0; m_flag = 0; m_wait = 0; m_rst_pulse = 0; m_cnt = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_prev_te = 0; m_flag = 0; m_wait = 0; m_rst_pulse = 0; m_cnt = 0;
            pkt_q.delete();
            exp_q.delete();
         end else begin
            m_rise      = te && !m_prev_te;
            m_prev_te   = te;
            m_sync_done = 0;
            m_rst_pulse = 0;
            if (pkt_q.size() > 0) begin
               if (rdy) begin
                  m_f = pkt_q.pop_front();
                  if (m_f == 2'b11) begin
                     m_sync_done = 1;
                     m_rst_pulse = 1;
                  end
               end
            end else if (m_wait) begin
               if (!te) begin
                  m_wait = 0; m_cnt = 0;
               end else if (iq) begin
                  m_wait = 0; m_cnt = 0;
                  if (!bme) begin
                     pkt_q.push_back(2'b01);
                     exp_q.push_back(4'b0100);
                  end
                  pkt_q.push_back(2'b11);
                  exp_q.push_back(4'b1100);
               end else if (m_cnt < MAX_WAIT) begin
                  m_cnt++;
               end
            end else if (te && (m_flag || m_rise || rm)) begin
               m_wait = 1;
            end
            if (m_rise) m_flag = 1;
            else if (m_sync_done) m_flag = 0;
         end
      end
   end

   task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("valid", 4'(pkt_valid), 4'(pkt_q.size() > 0));
            check("pending", 4'(resync_pending), 4'(m_wait || (pkt_q.size() > 0)));
            check("resync_rst", 4'(resync_rst), 4'(m_rst_pulse));
            check("overdue", 4'(resync_overdue), 4'(m_cnt == MAX_WAIT));
            if (pkt_q.size() > 0)
               check("fields_held", {pkt_format, pkt_subformat}, {pkt_q[0], 2'b00});
            else
               check("fields_idle", {pkt_format, pkt_subformat}, 4'b0000);
            if (pkt_valid && rdy && !rst) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_pkt: got %0h expected none at %0t",
                           {pkt_format, pkt_subformat}, $time);
               end else begin
                  check("pkt", {pkt_format, pkt_subformat}, exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_in(input bit t, input bit m, input bit q, input bit b, input bit r);
      te = t; rm = m; iq = q; bme = b; rdy = r;
   endtask

   task automatic run_until_idle(input int budget);
      int k;
      k = 0;
      set_in(1, 0, 1, 1, 1);
      while ((resync_pending || pkt_valid) && k < budget) begin
         tick(1);
         k++;
      end
      n_vec++;
      if (resync_pending || pkt_valid) begin
         n_fail++;
         $display("FAIL drain_timeout: got pending after %0d cycles expected idle", budget);
      end
      set_in(1, 0, 0, 1, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 1, 1);
      tick(1);
      mon_en = 1'b1;
      tick(1);
      rst = 1'b0;

      // Enable edge, empty branch map, ready tied high.
      tick(1);
      set_in(1, 0, 0, 1, 1); tick(3);
      set_in(1, 0, 1, 1, 1); tick(1);
      set_in(1, 0, 0, 1, 1); tick(5);

      // Resync max with outstanding branches: flush then sync.
      set_in(1, 1, 0, 1, 1); tick(1);
      set_in(1, 0, 0, 1, 1); tick(2);
      set_in(1, 0, 1, 0, 1); tick(1);
      set_in(1, 0, 0, 1, 1); tick(5);

      // Sync held with ready low; trace drops mid-hold.
      set_in(1, 1, 0, 1, 0); tick(1);
      set_in(1, 0, 1, 1, 0); tick(1);
      set_in(1, 0, 0, 1, 0); tick(2);
      set_in(0, 0, 0, 1, 0); tick(1);
      set_in(1, 0, 0, 1, 0); tick(2);
      set_in(1, 0, 0, 1, 1); tick(1);
      set_in(1, 0, 0, 1, 0); tick(3);
      run_until_idle(40);

      // Overdue: pending far longer than MAX_WAIT, then qualified.
      set_in(1, 1, 0, 1, 1); tick(1);
      set_in(1, 0, 0, 1, 1); tick(15);
      set_in(1, 0, 1, 1, 1); tick(1);
      set_in(1, 0, 0, 1, 1); tick(4);

      // Reset while the flush packet is stalled.
      set_in(1, 1, 0, 1, 0); tick(1);
      set_in(1, 0, 1, 0, 0); tick(1);
      set_in(1, 0, 0, 1, 0); tick(1);
      rst = 1'b1; tick(1);
      rst = 1'b0; tick(3);

      // Resync max coinciding with the enable edge.
      set_in(0, 0, 0, 1, 1); tick(2);
      set_in(1, 1, 0, 1, 1); tick(1);
      set_in(1, 0, 0, 1, 1); tick(1);
      set_in(1, 0, 1, 0, 1); tick(1);
      set_in(1, 0, 0, 1, 1); tick(5);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         te  = ($urandom_range(0, 19) != 0);
         rm  = ($urandom_range(0, 9) == 0);
         iq  = ($urandom_range(0, 3) == 0);
         bme = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 199) == 0);
         tick(1);
      end
      rst = 1'b0;
      run_until_idle(60);
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/trdb_sync_ctrl.md
# trdb_sync_ctrl

Sync-packet controller sitting directly downstream of the resync counter in the trace encoder. It consumes the counter's `resync_max` level and the first-qualified-instruction condition after trace enable, and schedules the resulting synchronisation sequence toward the packet emitter. The sequence is an optional branch-map flush packet followed by a format-3 sync packet, delivered over a valid/ready handshake. On completion it returns a one-cycle `resync_rst` pulse to the counter so counting restarts.

## Interface
- `MAX_WAIT`, default 1024: cycles a sync may stay pending without a qualified instruction before `resync_overdue_o` asserts.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `trace_enabled_i`  in  1  tracer enabled; rising edge requests a start sync.
- `resync_max_i`  in  1  level from resync counter: counter reached its maximum.
- `inst_qualified_i`  in  1  current retired instruction is qualified for tracing.
- `branch_map_empty_i`  in  1  branch map holds no unreported branches.
- `pkt_ready_i`  in  1  packet emitter accepts the current request.
- `pkt_valid_o`  out  1  packet request valid.
- `pkt_format_o`  out  2  requested packet format.
- `pkt_subformat_o`  out  2  requested subformat; meaningful for format 3 only.
- `resync_rst_o`  out  1  one-cycle pulse that resets the resync counter.
- `resync_pending_o`  out  1  a sync is scheduled but not yet accepted.
- `resync_overdue_o`  out  1  pending for `MAX_WAIT` cycles with no qualified instruction.

## Operation
- States: IDLE, WAIT_QUAL, FLUSH, SYNC.
- `start_flag`: set on `trace_enabled_i` 0→1, detected with an internal delayed copy reset to 0. Cleared on SYNC handshake or on `rst_i`.
- IDLE transition:
  - Goes to WAIT_QUAL when `trace_enabled_i` and (`start_flag` or `resync_max_i`).
  - The rising-edge cycle itself qualifies: the flag set and the transition happen together.
- WAIT_QUAL:
  - On `inst_qualified_i`: go to FLUSH if `!branch_map_empty_i`, else go to SYNC.
  - If `trace_enabled_i` is low, return to IDLE. `start_flag` is retained; `resync_max_i` is a level, so it is re-evaluated on re-enable.
- FLUSH:
  - Drives `pkt_valid_o`=1, format `2'b01` (branch-full), subformat `2'b00`.
  - On `pkt_ready_i`, go to SYNC.
- SYNC:
  - Drives `pkt_valid_o`=1, format `2'b11`, subformat `2'b00` (start).
  - On `pkt_ready_i`, go to IDLE and clear `start_flag`.
- Handshake rules:
  - Once `pkt_valid_o` rises, it and the format/subformat fields hold stable until the cycle `pkt_ready_i` is sampled high.
  - Trace disable in FLUSH or SYNC does not abort; the sequence completes, then the FSM returns to IDLE.
- `resync_pending_o` = state != IDLE, registered from state.
- Overdue counter:
  - Width `$clog2(MAX_WAIT+1)`.
  - Increments each cycle in WAIT_QUAL without `inst_qualified_i`, saturating at `MAX_WAIT`.
  - Cleared on any exit from WAIT_QUAL.
  - `resync_overdue_o` = (counter == `MAX_WAIT`).
- Simultaneous events:
  - `resync_max_i` while in FLUSH or SYNC is absorbed: it is satisfied by the SYNC in flight.
  - `resync_max_i` and `start_flag` both set produce exactly one sequence.

## Timing
- Reset values: state IDLE; `pkt_valid_o` 0; `pkt_format_o` and `pkt_subformat_o` `2'b00`; `resync_rst_o` 0; `resync_pending_o` 0; `resync_overdue_o` 0; counter 0; `start_flag` 0.
- All outputs are registered.
- IDLE→WAIT_QUAL: `resync_pending_o` rises one cycle after the trigger.
- Qualified instruction at cycle N: `pkt_valid_o` high from N+1.
- FLUSH accepted at cycle M: SYNC request valid at M+1 (back-to-back, no gap).
- SYNC accepted at cycle K:
  - `pkt_valid_o` low at K+1.
  - `resync_rst_o` high during K+1 only.
  - `resync_pending_o` low at K+1.
- `rst_i` mid-sequence forces IDLE next edge and drops `pkt_valid_o` without completing the handshake. No `resync_rst_o` pulse is emitted.

## Structure
- `trdb_pkg` gains:
  - Format constants `F_BRANCH_FULL`=2'b01 and `F_SYNC`=2'b11.
  - Subformat constant `SF_START`=2'b00.
  - Typedef `trdb_sync_state_e` for the four states.
- Sub-module `trdb_sat_counter`: parameterised saturating counter with clear/enable. It implements the overdue counter and is reusable by the resync counter.

## Test plan
- Enable at cycle 2, qualified at cycle 5, branch map empty, ready tied 1 -> SYNC valid at cycle 6 with format 2'b11/subformat 2'b00; `resync_rst_o` pulse at cycle 7.
- `resync_max_i`=1, qualified with `branch_map_empty_i`=0, ready=1 -> FLUSH (2'b01) valid for 1 cycle, then SYNC (2'b11) the next cycle, then exactly one `resync_rst_o` pulse.
- SYNC valid with ready held low for 5 cycles -> `pkt_valid_o` and fields stable for all 5 cycles; a `trace_enabled_i` drop in the middle does not deassert valid.
- `MAX_WAIT`=8, pending with no qualified instruction -> `resync_overdue_o` high after 8 cycles and held; a qualified instruction clears it on exit from WAIT_QUAL.
- `rst_i` asserted in FLUSH -> next cycle all outputs at reset values; no `resync_rst_o` pulse.
- `resync_max_i` and trace-enable rising edge in the same cycle -> a single FLUSH/SYNC sequence and a single `resync_rst_o` pulse.
